// File: rtl/mem_arb_pkg.sv
// Shared definitions for the round-robin memory arbiter.
//   clog2 / port_id_w : sizing helpers for the encoded port id
//   tag_t             : read tag {valid, port_id} carried alongside an issued read
//   ARB_RR / ARB_FIXED: arbitration mode selectors
package mem_arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Tag id field is sized for up to 256 requesters so the struct can live here,
  // independent of any particular NUM_PORTS.
  localparam int TAG_ID_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Encoded port id width; a 1-bit minimum keeps every vector legal.
  function automatic int port_id_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] port_id;
  } tag_t;

endpackage

// File: rtl/mem_arbiter_rr_grant.sv
// Grant generator: combinational one-hot grant over the valid vector, either
// round-robin from the priority pointer or fixed lowest-index priority.
//   clock, reset_n : clock and synchronous active-low reset
//   valid          : per-port request pending
//   grant          : one-hot grant (all zero in reset or when nothing is valid)
//   grant_id       : encoded index of the granted port
//   grant_any      : a grant is being given this cycle
module rr_grant
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 3,
  parameter int PRIORITY_MODE = ARB_RR,
  localparam int PORT_ID_W    = port_id_w(NUM_PORTS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] valid,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PORT_ID_W-1:0] grant_id,
  output logic                 grant_any
);

  logic [PORT_ID_W-1:0] ptr;

  // Search starts at ptr and wraps by subtraction, so non-power-of-two port
  // counts never index past the last port.
  always_comb begin : pick
    int idx;
    idx       = 0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    if (reset_n) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (PRIORITY_MODE == ARB_FIXED) begin
          idx = k;
        end else begin
          idx = int'(ptr) + k;
          if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        end
        if (!grant_any && valid[idx]) begin
          grant[idx] = 1'b1;
          grant_id   = PORT_ID_W'(idx);
          grant_any  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (grant_any && (PRIORITY_MODE == ARB_RR)) begin
      ptr <= (grant_id == PORT_ID_W'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port arbiter in front of a single shared data memory.
//   clock, reset_n      : clock and synchronous active-low reset
//   req_valid/write     : per-port request and direction (1 = write)
//   req_addr/req_wdata  : per-port request fields, port i at [i*W +: W]
//   req_ready           : one-hot grant; valid&ready accepts the request
//   rsp_valid/rsp_rdata : one-cycle read response pulse and held read data
//   mem_read/mem_write  : registered memory strobes
//   mem_addr/mem_wdata  : registered address / write data (hold when idle)
//   mem_rdata           : memory read data, valid READ_LATENCY cycles after mem_read
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 3,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int READ_LATENCY  = 1,
  parameter int PRIORITY_MODE = ARB_RR
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS-1:0]          req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [NUM_PORTS*DATA_W-1:0]   rsp_rdata,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int PORT_ID_W = port_id_w(NUM_PORTS);

  logic [NUM_PORTS-1:0] grant;
  logic [PORT_ID_W-1:0] grant_id;
  logic                 grant_any;
  logic                 hs_p0;
  logic [PORT_ID_W-1:0] issue_id_p1;
  tag_t                 tag_p [READ_LATENCY];
  tag_t                 tag_out;

  rr_grant #(
    .NUM_PORTS     (NUM_PORTS),
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_grant (
    .clock     (clock),
    .reset_n   (reset_n),
    .valid     (req_valid),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // Only valid ports are ever granted, so any grant is a completed handshake.
  assign req_ready = grant;
  assign hs_p0     = grant_any;

  // ---- stage p0 -> p1: register the accepted request onto the memory bus
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      issue_id_p1 <= '0;
    end else begin
      mem_read  <= hs_p0 && !req_write[grant_id];
      mem_write <= hs_p0 &&  req_write[grant_id];
      if (hs_p0) begin
        mem_addr    <= req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
        mem_wdata   <= req_wdata[int'(grant_id)*DATA_W +: DATA_W];
        issue_id_p1 <= grant_id;
      end
    end
  end

  // ---- stage p1 -> p1+READ_LATENCY: read tags follow the memory latency
  // Writes enter as invalid tags, keeping the shift cadence one slot per cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        tag_p[k] <= '0;
      end
    end else begin
      tag_p[0].valid   <= mem_read;
      tag_p[0].port_id <= TAG_ID_W'(issue_id_p1);
      for (int k = 1; k < READ_LATENCY; k++) begin
        tag_p[k] <= tag_p[k-1];
      end
    end
  end

  assign tag_out = tag_p[READ_LATENCY-1];

  // ---- response stage: steer mem_rdata to the tagged port
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_out.valid) begin
        rsp_valid[tag_out.port_id] <= 1'b1;
        rsp_rdata[int'(tag_out.port_id)*DATA_W +: DATA_W] <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised N-port round-robin arbiter that connects the cores, the GPU and any future masters to the single shared data memory. Each requester uses a valid/ready request channel and a read-response channel. The arbiter issues at most one memory transaction per cycle and guarantees starvation-free access. It returns read data to the originating port after a fixed, parametrised memory latency.

## Interface
- NUM_PORTS, 3, number of requesters (≥2; port 0 = core0, 1 = core1, 2 = GPU)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- READ_LATENCY, 1, cycles from mem_read high to mem_rdata valid (≥1)
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_PORTS  per-port request pending
- req_write  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_W  port i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_PORTS*DATA_W  write data, same packing
- req_ready  out  NUM_PORTS  one-hot grant; the request is accepted when valid&ready
- rsp_valid  out  NUM_PORTS  one-cycle read-data pulse
- rsp_rdata  out  NUM_PORTS*DATA_W  read data; held until the next response to that port
- mem_read  out  1  registered read strobe
- mem_write  out  1  registered write strobe
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  shared memory read data

## Operation
- Grant logic is combinational:
  - req_ready is one-hot or zero.
  - At most one port is granted per cycle.
  - Only a port with req_valid=1 is granted.
- Round-robin mode:
  - Priority pointer ptr is in 0..NUM_PORTS-1.
  - The search starts at ptr and wraps modulo NUM_PORTS; this applies to non-power-of-two NUM_PORTS as well.
  - After a grant to port g, ptr <= (g+1) mod NUM_PORTS.
  - With no grant, ptr holds.
- Fixed-priority mode: the lowest-index valid port wins and ptr is unused.
- Issue:
  - On handshake, the memory outputs register the granted port's address, data and direction.
  - The unused strobe is 0.
  - With no handshake, both strobes are 0 and addr/wdata hold their last value.
- Read tag pipeline:
  - Each issued read pushes {valid, port_id} into a shift register of depth READ_LATENCY.
  - At the output, mem_rdata is latched into rsp_rdata[port_id] and rsp_valid[port_id] is pulsed.
  - Writes push an invalid tag and produce no response.
- Back-to-back reads from any mix of ports are fully pipelined, one per cycle.
- Requesters must hold req_valid and the request fields stable until accepted.
- The arbiter makes no assumption about requester behaviour after acceptance.

## Timing
- Reset value of every output is 0. This covers:
  - req_ready (combinational, forced 0 while reset_n=0)
  - rsp_valid and rsp_rdata
  - mem_read, mem_write, mem_addr and mem_wdata
  - ptr, which resets to 0, and the tag pipeline, which is cleared.
- Read latency, for a handshake in cycle T:
  - mem_read=1 in T+1.
  - mem_rdata is sampled in T+1+READ_LATENCY.
  - rsp_valid=1 in T+2+READ_LATENCY.
  - The default total is 3 cycles.
- Write: mem_write=1 in cycle T+1 and no response follows.
- Fairness: in round-robin mode, a continuously valid port is granted within NUM_PORTS cycles of raising req_valid.
- Reset mid-operation: reset_n=0 drops all in-flight reads. No rsp_valid is generated for them, including data arriving after reset is released.
- Simultaneous response and new issue to the same port in one cycle are independent. No stall exists; the arbiter never backpressures responses.

## Structure
- Package mem_arb_pkg holds:
  - function clog2 and the localparam PORT_ID_W = max(1, clog2(NUM_PORTS))
  - the tag struct {valid, port_id}
  - mode constants ARB_RR = 0 and ARB_FIXED = 1
- Sub-module rr_grant contains ptr, the valid vector and the mode. It outputs the one-hot grant and the encoded port id, and updates ptr.
- The top level holds the issue registers and the tag shift register.

## Test plan
- Single read: port1 reads 0x40 with memory model data 0xDEADBEEF → mem_read/mem_addr=0x40 in T+1; rsp_valid[1]=1 with rsp_rdata port1 = 0xDEADBEEF in T+3; no other rsp_valid.
- Round-robin rotation: all three ports hold req_valid for 6 cycles after reset → grant order 0,1,2,0,1,2 and ptr=0 at the end.
- Fixed priority: PRIORITY_MODE=1 with ports 0 and 2 both valid → port 0 is granted every cycle and port 2 only after port 0 deasserts.
- Pipelined mixed traffic:
  - Stimulus: port0 read A=0x10, port1 write 0x20←0x1234, port2 read 0x30 on consecutive cycles.
  - Response: mem strobes R, W, R; responses only to ports 0 and 2, in order, with the correct data.
- Latency sweep: READ_LATENCY=4 with NUM_PORTS=5 and back-to-back reads from ports 4,3,0 → responses in T+6, T+7 and T+8 to the matching ports, and wrap from port 4 to port 0.
- Reset mid-flight: assert reset_n=0 for 1 cycle directly after a read handshake → all outputs are 0; no rsp_valid occurs in the following 10 cycles; the next grant goes to port 0.
